// File: rtl/ddcb_pkg.sv
// -----------------------------------------------------------------------------
// ddcb_pkg
// Shared definitions for the cascaded delay-line controller:
//   - ddcb_ctrl_state_t : controller FSM states
//   - SEL_* constants   : per-stage 2-bit select encodings (2'b11 is never used)
// -----------------------------------------------------------------------------
package ddcb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SLEW       = 2'd1,
        SWEEP_DOWN = 2'd2,
        SWEEP_HOLD = 2'd3
    } ddcb_ctrl_state_t;

    localparam logic [1:0] SEL_DIRECT = 2'b00;  // stage delay 0: direct path
    localparam logic [1:0] SEL_1BUF   = 2'b01;  // stage delay 1: one buffer
    localparam logic [1:0] SEL_2BUF   = 2'b10;  // stage delay 2: two buffers

endpackage

// File: rtl/ddcb_delay_ctrl_code2sel.sv
// -----------------------------------------------------------------------------
// ddcb_code2sel
// Purely combinational linear-code to select-bus mapper. Stages are filled
// from stage 0 upward, so a +/-1 code change alters exactly one stage field.
//   code : linear delay code, 0 .. 2*NMBR_CASCADES
//   sel  : stage selects, stage i on bits [2i+1:2i]
// -----------------------------------------------------------------------------
module ddcb_code2sel
    import ddcb_pkg::*;
#(
    parameter int NMBR_CASCADES = 4,
    parameter int CODE_W        = $clog2(2*NMBR_CASCADES+1)
) (
    input  logic [CODE_W-1:0]          code,
    output logic [2*NMBR_CASCADES-1:0] sel
);

    always_comb begin
        // NOTE: default every combinational output first so no path leaves it
        // unassigned and infers a latch.
        sel = '0;
        for (int i = 0; i < NMBR_CASCADES; i++) begin
            if (int'(code) >= 2*i + 2)
                sel[2*i +: 2] = SEL_2BUF;
            else if (int'(code) == 2*i + 1)
                sel[2*i +: 2] = SEL_1BUF;
            else
                sel[2*i +: 2] = SEL_DIRECT;
        end
    end

endmodule

// File: rtl/ddcb_delay_ctrl.sv
// -----------------------------------------------------------------------------
// ddcb_delay_ctrl
// Sequential controller for the cascaded digitally-controlled delay line.
// Moves the applied code one unit per clock toward a requested target so only
// one stage select changes per edge, and offers a calibration sweep that walks
// the line down to 0 and then up through every code with a programmable dwell.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : request present
//   req_ready   : request accepted when req_valid && req_ready
//   req_code    : static target code (clipped to CMAX)
//   req_sweep   : 1 = sweep request (req_code ignored)
//   dwell       : cycles-per-code minus 1, sampled on accept
//   abort       : synchronous abort to IDLE, code held
//   select      : registered stage selects, always map(cur_code)
//   cur_code    : code currently applied
//   busy        : state != IDLE
//   code_err    : one-cycle pulse after accepting a clipped code
//   sweep_done  : one-cycle pulse after the final sweep hold expires
// -----------------------------------------------------------------------------
module ddcb_delay_ctrl
    import ddcb_pkg::*;
#(
    parameter int NMBR_CASCADES = 4,
    parameter int CODE_W        = $clog2(2*NMBR_CASCADES+1),
    parameter int DWELL_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [CODE_W-1:0]          req_code,
    input  logic                       req_sweep,
    input  logic [DWELL_W-1:0]         dwell,
    input  logic                       abort,
    output logic [2*NMBR_CASCADES-1:0] select,
    output logic [CODE_W-1:0]          cur_code,
    output logic                       busy,
    output logic                       code_err,
    output logic                       sweep_done
);

    localparam int                CMAX   = 2*NMBR_CASCADES;
    localparam logic [CODE_W-1:0] CMAX_C = CODE_W'(CMAX);
    localparam logic [CODE_W-1:0] ONE_C  = CODE_W'(1);

    ddcb_ctrl_state_t state_q, state_d;

    logic [CODE_W-1:0]          code_q,   code_d;
    logic [CODE_W-1:0]          target_q, target_d;
    logic [DWELL_W-1:0]         dwell_q,  dwell_d;
    logic [DWELL_W-1:0]         cnt_q,    cnt_d;
    logic [2*NMBR_CASCADES-1:0] sel_q,    sel_d;
    logic                       code_err_q, code_err_d;
    logic                       sweep_done_q, sweep_done_d;

    // Map the next code so the select register is loaded on the same edge as
    // the code register and the two never disagree.
    ddcb_code2sel #(
        .NMBR_CASCADES (NMBR_CASCADES),
        .CODE_W        (CODE_W)
    ) u_code2sel (
        .code (code_d),
        .sel  (sel_d)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q      <= IDLE;
            code_q       <= '0;
            target_q     <= '0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            sel_q        <= '0;
            code_err_q   <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            target_q     <= target_d;
            dwell_q      <= dwell_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            code_err_q   <= code_err_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        target_d     = target_q;
        dwell_d      = dwell_q;
        cnt_d        = cnt_q;
        code_err_d   = 1'b0;
        sweep_done_d = 1'b0;

        if (abort) begin
            // Freeze the line where it is; no pulses on an aborted operation.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (req_sweep) begin
                            target_d = '0;
                            dwell_d  = dwell;
                            state_d  = SWEEP_DOWN;
                        end else begin
                            if (req_code > CMAX_C) begin
                                target_d   = CMAX_C;
                                code_err_d = 1'b1;
                            end else begin
                                target_d = req_code;
                            end
                            state_d = SLEW;
                        end
                    end
                end

                SLEW: begin
                    if (code_q == target_q) begin
                        state_d = IDLE;
                    end else begin
                        code_d = (code_q < target_q) ? code_q + ONE_C
                                                     : code_q - ONE_C;
                        // Leave on the edge that lands on the target.
                        if (code_d == target_q)
                            state_d = IDLE;
                    end
                end

                SWEEP_DOWN: begin
                    if (code_q != '0)
                        code_d = code_q - ONE_C;
                    // The edge that reaches 0 also starts the first hold.
                    if (code_q <= ONE_C) begin
                        cnt_d   = dwell_q;
                        state_d = SWEEP_HOLD;
                    end
                end

                SWEEP_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (code_q < CMAX_C) begin
                        code_d = code_q + ONE_C;
                        cnt_d  = dwell_q;
                    end else begin
                        sweep_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy      = (state_q != IDLE);
        req_ready = (state_q == IDLE) && !abort;
    end

    assign select     = sel_q;
    assign cur_code   = code_q;
    assign code_err   = code_err_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: doc/ddcb_delay_ctrl.md
# ddcb_delay_ctrl

Sequential controller for the cascaded digitally-controlled delay line. It converts a linear delay code into the per-stage 2-bit select bus and moves the line toward the requested code one unit per clock edge, so that only one stage select changes per edge and the delay path does not glitch. It also provides a calibration sweep mode with a programmable dwell time. It sits between the calibration/config logic and the delay-line select inputs.

## Interface
Parameters:
- `NMBR_CASCADES`, default 4: number of delay stages; minimum 2.
- `CODE_W`, default `$clog2(2*NMBR_CASCADES+1)`: width of the delay code.
- `DWELL_W`, default 8: width of the sweep dwell count.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller accepts a request.
- `req_code` in CODE_W: target code (static mode).
- `req_sweep` in 1: 1 = sweep request; `req_code` is ignored.
- `dwell` in DWELL_W: cycles-per-code minus 1, sampled on accept.
- `abort` in 1: synchronous abort.
- `select` out 2*NMBR_CASCADES: stage selects; stage i uses bits [2i+1:2i].
- `cur_code` out CODE_W: code currently applied.
- `busy` out 1: high when state ≠ IDLE.
- `code_err` out 1: one-cycle pulse when the requested code was clipped.
- `sweep_done` out 1: one-cycle pulse at the end of a sweep.

## Operation
- Code range is 0..CMAX, where CMAX = 2*NMBR_CASCADES.
- Stage i delay value = min(2, max(0, code − 2i)).
- Select encoding per stage: delay 0 → 2'b00 (I0, direct), delay 1 → 2'b01 (I1), delay 2 → 2'b10 (I2). 2'b11 is never driven.
- Stage delays are filled from stage 0 upward. Any ±1 code change therefore alters exactly one stage field.
- A request is accepted when `req_valid && req_ready`. `req_ready = (state==IDLE) && !abort`.
- Static request: target = min(`req_code`, CMAX). If `req_code` > CMAX, `code_err` pulses on the cycle after accept. The FSM goes to SLEW.
- Sweep request: target = 0, the dwell count is latched, and the FSM goes to SWEEP_DOWN.

State machine:
- IDLE: hold `cur_code`.
- SLEW: each edge moves `cur_code` ±1 toward the target. On the edge where `cur_code` equals the target (or already equals it), go to IDLE.
- SWEEP_DOWN: step −1 per edge until `cur_code` = 0. Then load the dwell counter with `dwell` and go to SWEEP_HOLD.
- SWEEP_HOLD: decrement the dwell counter each edge. When it reaches 0:
  - if `cur_code` < CMAX: step +1 and reload the counter;
  - else: pulse `sweep_done` and go to IDLE.
- `abort` high at an edge forces IDLE from any state. `cur_code` and `select` hold their current values, and no pulse is generated.
- A request arriving while busy is not accepted; `req_valid` must stay asserted until accepted.

## Timing
- Reset values: state IDLE, `cur_code` 0, `select` all 0, `busy` 0, `code_err` 0, `sweep_done` 0. `req_ready` is 1 after reset if `abort` = 0.
- `select` is registered and updated on the same edge as `cur_code`, so `select` = map(`cur_code`) at all times.
- Accept at edge T: `busy` rises after T. The first code step happens at edge T+1.
- A static move of distance d returns to IDLE at edge T+max(d,1). `busy` is high for max(d,1) cycles.
- In sweep mode, each code 0..CMAX is held exactly `dwell`+1 cycles. `sweep_done` is high for the cycle after the final hold expires.
- At most one 2-bit stage field changes per edge, under all conditions.

## Structure
- Package `ddcb_pkg` holds:
  - the state enum `ddcb_ctrl_state_t` (IDLE, SLEW, SWEEP_DOWN, SWEEP_HOLD);
  - the select constants `SEL_DIRECT` = 2'b00, `SEL_1BUF` = 2'b01, `SEL_2BUF` = 2'b10.
- Sub-module `ddcb_code2sel`: purely combinational code→select mapper, parametrised on `NMBR_CASCADES`. The controller registers its output.
- The controller contains the FSM, the code register, the dwell counter and the pulse registers.

## Test plan
- Reset with `rst_n` low mid-slew → immediately `select` = 0, `cur_code` = 0, `busy` = 0. After release, `req_ready` = 1.
- N=4, static request code 5 from 0 → `cur_code` steps 1..5 on 5 consecutive edges, then `select` = 8'h1A. `busy` is high for 5 cycles, and exactly one stage field changes per edge.
- N=4, `req_code` = 12 → `code_err` pulses once, and the line slews to 8 with `select` = 8'hAA. A subsequent request of 8 → `busy` high for 1 cycle, no change.
- N=4, sweep with `dwell` = 2 from `cur_code` = 3 → 3 down-steps to 0, then each of the codes 0..8 is held 3 cycles. `sweep_done` pulses once, the final `select` = 8'hAA, and the total `busy` time is 3+27 = 30 cycles.
- Request 8 from 0, `abort` asserted when `cur_code` = 3 → `cur_code` holds at 3 and `select` = 8'h06. `req_ready` stays low while `abort` is high and returns to 1 the cycle after `abort` deasserts. No `sweep_done`/`code_err` pulse occurs.
- `req_valid` toggled with new codes while busy → ignored (no target change). A request held through completion is accepted on the first IDLE cycle.
